// File: rtl/bp_me_pkg.sv
// Shared types for the BP memory-end burst arbiter.
// Holds the arbiter state enum and the 2-way priority pick.
package bp_me_pkg;

  typedef enum logic {
    e_arb_idle,
    e_arb_data
  } bp_me_burst_arb_state_e;

  // Priority source wins if valid, otherwise the other one.
  function automatic logic rr_pick(
    input logic [1:0] v,
    input logic       p
  );
    return v[p] ? p : ~p;
  endfunction

endpackage

// File: rtl/bp_me_lce_cmd_burst_arb.sv
// Burst-aware 2:1 round-robin arbiter for the LCE command channel.
// Ports: per-source header/data BP Burst in, merged burst out, grant_o, error_o.
module bp_me_lce_cmd_burst_arb
  import bp_me_pkg::*;
#(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int max_beats_p    = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [2*header_width_p-1:0] src_header_i,
  input  logic [1:0]                  src_header_v_i,
  output logic [1:0]                  src_header_ready_and_o,
  input  logic [1:0]                  src_has_data_i,
  input  logic [2*data_width_p-1:0]   src_data_i,
  input  logic [1:0]                  src_data_v_i,
  output logic [1:0]                  src_data_ready_and_o,
  input  logic [1:0]                  src_last_i,
  output logic [header_width_p-1:0]   cmd_header_o,
  output logic                        cmd_header_v_o,
  input  logic                        cmd_header_ready_and_i,
  output logic                        cmd_has_data_o,
  output logic [data_width_p-1:0]     cmd_data_o,
  output logic                        cmd_data_v_o,
  input  logic                        cmd_data_ready_and_i,
  output logic                        cmd_last_o,
  output logic                        grant_o,
  output logic                        error_o
);

  localparam int cnt_w_lp = $clog2(max_beats_p+1);
  localparam int hw_lp    = header_width_p;
  localparam int dw_lp    = data_width_p;

  bp_me_burst_arb_state_e state_q, state_d;
  logic                prio_q, prio_d;
  logic                grant_q, grant_d;
  logic                err_q, err_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  logic idle, busy, winner;
  logic hdr_hs, data_hs;

  // Outputs are gated by reset so they drop asynchronously.
  assign idle = reset_n_i && (state_q == e_arb_idle);
  assign busy = reset_n_i && (state_q == e_arb_data);

  assign winner = rr_pick(src_header_v_i, prio_q);

  assign cmd_header_o = winner
    ? src_header_i[2*hw_lp-1 -: hw_lp]
    : src_header_i[hw_lp-1:0];
  assign cmd_header_v_o = idle && (|src_header_v_i);
  assign cmd_has_data_o = src_has_data_i[winner];

  assign cmd_data_o = grant_q
    ? src_data_i[2*dw_lp-1 -: dw_lp]
    : src_data_i[dw_lp-1:0];
  assign cmd_data_v_o = busy && src_data_v_i[grant_q];
  assign cmd_last_o   = src_last_i[grant_q];

  assign hdr_hs  = cmd_header_v_o && cmd_header_ready_and_i;
  assign data_hs = cmd_data_v_o && cmd_data_ready_and_i;

  assign grant_o = grant_q;
  assign error_o = err_q;

  always_comb begin
    src_header_ready_and_o = '0;
    src_data_ready_and_o   = '0;
    src_header_ready_and_o[winner] =
      cmd_header_v_o && cmd_header_ready_and_i;
    src_data_ready_and_o[grant_q] =
      busy && cmd_data_ready_and_i;
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      e_arb_idle: begin
        if (hdr_hs) begin
          grant_d = winner;
          if (cmd_has_data_o) begin
            state_d = e_arb_data;
            cnt_d   = '0;
          end else begin
            prio_d = ~winner;
          end
        end
      end
      e_arb_data: begin
        if (data_hs) begin
          cnt_d = cnt_q + cnt_w_lp'(1);
          if (cmd_last_o) begin
            state_d = e_arb_idle;
            prio_d  = ~grant_q;
          end else if (cnt_q == cnt_w_lp'(max_beats_p-1)) begin
            // Runaway burst: release the channel, flag it.
            err_d   = 1'b1;
            state_d = e_arb_idle;
            prio_d  = ~grant_q;
          end
        end
      end
      default: state_d = e_arb_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_arb_idle;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_me_lce_cmd_burst_arb.sv
// Scoreboard bench for bp_me_lce_cmd_burst_arb.
// Tasks drive sources and push expected beats; a monitor pops them.
module tb_bp_me_lce_cmd_burst_arb;

  logic         clk;
  logic         rst_n;
  logic [127:0] src_header_i;
  logic [1:0]   src_header_v_i;
  logic [1:0]   src_header_ready_and_o;
  logic [1:0]   src_has_data_i;
  logic [127:0] src_data_i;
  logic [1:0]   src_data_v_i;
  logic [1:0]   src_data_ready_and_o;
  logic [1:0]   src_last_i;
  logic [63:0]  cmd_header_o;
  logic         cmd_header_v_o;
  logic         hdr_rdy;
  logic         cmd_has_data_o;
  logic [63:0]  cmd_data_o;
  logic         cmd_data_v_o;
  logic         dat_rdy;
  logic         cmd_last_o;
  logic         grant_o;
  logic         error_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          hdr;
    int          src;
    logic [63:0] val;
    bit          flag;
  } exp_t;

  exp_t exp_q[$];

  bp_me_lce_cmd_burst_arb #(
    .header_width_p(64),
    .data_width_p(64),
    .max_beats_p(8)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .src_header_i(src_header_i),
    .src_header_v_i(src_header_v_i),
    .src_header_ready_and_o(src_header_ready_and_o),
    .src_has_data_i(src_has_data_i),
    .src_data_i(src_data_i),
    .src_data_v_i(src_data_v_i),
    .src_data_ready_and_o(src_data_ready_and_o),
    .src_last_i(src_last_i),
    .cmd_header_o(cmd_header_o),
    .cmd_header_v_o(cmd_header_v_o),
    .cmd_header_ready_and_i(hdr_rdy),
    .cmd_has_data_o(cmd_has_data_o),
    .cmd_data_o(cmd_data_o),
    .cmd_data_v_o(cmd_data_v_o),
    .cmd_data_ready_and_i(dat_rdy),
    .cmd_last_o(cmd_last_o),
    .grant_o(grant_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        stall_q = 1'b0;
  logic [63:0] stall_d = '0;

  // Scoreboard monitor: every output handshake must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_q && cmd_data_v_o) begin
        tests++;
        if (cmd_data_o !== stall_d) begin
          fails++;
          $display("FAIL stall_stable got %h exp %h", cmd_data_o, stall_d);
        end
      end
      stall_q = cmd_data_v_o && !dat_rdy;
      stall_d = cmd_data_o;
      if (cmd_data_v_o) begin
        tests++;
        if (cmd_header_v_o !== 1'b0 || src_header_ready_and_o !== 2'b00) begin
          fails++;
          $display("FAIL hdr_locked got v=%b rdy=%b exp 0/00",
                   cmd_header_v_o, src_header_ready_and_o);
        end
      end
      if (cmd_header_v_o && hdr_rdy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL hdr_unexpected got %h exp none", cmd_header_o);
        end else begin
          e = exp_q.pop_front();
          if (!e.hdr || cmd_header_o !== e.val ||
              cmd_has_data_o !== e.flag ||
              src_header_ready_and_o !== (e.src != 0 ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL hdr got %h hd=%b rdy=%b exp %h hd=%b src=%0d",
                     cmd_header_o, cmd_has_data_o, src_header_ready_and_o,
                     e.val, e.flag, e.src);
          end
        end
      end
      if (cmd_data_v_o && dat_rdy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL data_unexpected got %h exp none", cmd_data_o);
        end else begin
          e = exp_q.pop_front();
          if (e.hdr || cmd_data_o !== e.val || cmd_last_o !== e.flag ||
              grant_o !== e.src[0]) begin
            fails++;
            $display("FAIL data got %h last=%b g=%b exp %h last=%b g=%0d",
                     cmd_data_o, cmd_last_o, grant_o, e.val, e.flag, e.src);
          end
        end
      end
    end
  end

  function automatic logic [63:0] beat_val(logic [63:0] h, int b);
    return {h[55:0], 8'(b)};
  endfunction

  task automatic push_msg(int s, logic [63:0] h, int nb, bit with_last);
    exp_q.push_back('{1'b1, s, h, nb > 0});
    for (int b = 0; b < nb; b++)
      exp_q.push_back('{1'b0, s, beat_val(h, b),
                        with_last && (b == nb - 1)});
  endtask

  task automatic send(int s, logic [63:0] h, int nb, bit with_last);
    int k;
    src_header_i[s*64 +: 64] = h;
    src_has_data_i[s] = (nb > 0);
    src_header_v_i[s] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!src_header_ready_and_o[s] && k < 300);
    tests++;
    if (!src_header_ready_and_o[s]) begin
      fails++;
      $display("FAIL hdr_timeout src=%0d got rdy=0 exp 1", s);
    end
    @(posedge clk); #1;
    src_header_v_i[s] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      src_data_i[s*64 +: 64] = beat_val(h, b);
      src_last_i[s] = with_last && (b == nb - 1);
      src_data_v_i[s] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!src_data_ready_and_o[s] && k < 300);
      tests++;
      if (!src_data_ready_and_o[s]) begin
        fails++;
        $display("FAIL data_timeout src=%0d got rdy=0 exp 1", s);
      end
      @(posedge clk); #1;
    end
    src_data_v_i[s] = 1'b0;
    src_last_i[s] = 1'b0;
  endtask

  task automatic drain(string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk); k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d left exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_header_v_i = 2'b11;
    src_data_v_i = 2'b11;
    hdr_rdy = 1'b1;
    dat_rdy = 1'b1;
    #1;
    tests++;
    if ({cmd_header_v_o, cmd_data_v_o, src_header_ready_and_o,
         src_data_ready_and_o, grant_o, error_o} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outs got hv=%b dv=%b hr=%b dr=%b g=%b e=%b exp 0",
               cmd_header_v_o, cmd_data_v_o, src_header_ready_and_o,
               src_data_ready_and_o, grant_o, error_o);
    end
    @(negedge clk);
    src_header_v_i = 2'b00;
    src_data_v_i = 2'b00;
    src_has_data_i = 2'b00;
    src_last_i = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (cmd_header_v_o !== 1'b0 || cmd_data_v_o !== 1'b0 ||
        grant_o !== 1'b0 || error_o !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got hv=%b dv=%b g=%b e=%b exp 0",
               cmd_header_v_o, cmd_data_v_o, grant_o, error_o);
    end
  endtask

  task automatic test_single_header();
    push_msg(0, 64'h11, 0, 1'b0);
    src_header_i[63:0] = 64'h11;
    src_has_data_i[0] = 1'b0;
    src_header_v_i[0] = 1'b1;
    #1;
    tests++;
    if (cmd_header_v_o !== 1'b1 || cmd_header_o !== 64'h11 ||
        src_header_ready_and_o !== 2'b01) begin
      fails++;
      $display("FAIL single_hdr got v=%b h=%h rdy=%b exp 1/11/01",
               cmd_header_v_o, cmd_header_o, src_header_ready_and_o);
    end
    @(posedge clk); #1;
    src_header_v_i[0] = 1'b0;
    tests++;
    if (grant_o !== 1'b0) begin
      fails++;
      $display("FAIL single_grant got %b exp 0", grant_o);
    end
    drain("single");
  endtask

  task automatic test_contention(int first);
    for (int i = 0; i < 8; i++) begin
      int s = first ^ (i & 1);
      push_msg(s, 64'h200 + 64'(s * 16 + i / 2), 0, 1'b0);
    end
    fork
      for (int j = 0; j < 4; j++) send(0, 64'h200 + 64'(j), 0, 1'b0);
      for (int j = 0; j < 4; j++) send(1, 64'h210 + 64'(j), 0, 1'b0);
    join
    drain("contention");
  endtask

  task automatic test_burst_pair();
    push_msg(0, 64'hA0, 8, 1'b1);
    push_msg(1, 64'hB1, 8, 1'b1);
    fork
      send(0, 64'hA0, 8, 1'b1);
      send(1, 64'hB1, 8, 1'b1);
    join
    drain("burst_pair");
    tests++;
    if (error_o !== 1'b0 || grant_o !== 1'b1) begin
      fails++;
      $display("FAIL burst_pair_end got e=%b g=%b exp 0/1", error_o, grant_o);
    end
  endtask

  task automatic test_backpressure();
    push_msg(1, 64'hC3, 8, 1'b1);
    fork
      send(1, 64'hC3, 8, 1'b1);
      repeat (40) begin @(posedge clk); #1; dat_rdy = ~dat_rdy; end
    join
    dat_rdy = 1'b1;
    drain("backpressure");
    tests++;
    if (error_o !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_err got %b exp 0", error_o);
    end
  endtask

  task automatic test_overflow();
    push_msg(1, 64'hD5, 8, 1'b0);
    push_msg(0, 64'hE7, 0, 1'b0);
    send(1, 64'hD5, 8, 1'b0);
    src_data_v_i[1] = 1'b1;
    #1;
    tests++;
    if (error_o !== 1'b1 || cmd_data_v_o !== 1'b0 ||
        src_data_ready_and_o !== 2'b00) begin
      fails++;
      $display("FAIL overflow got e=%b dv=%b dr=%b exp 1/0/00",
               error_o, cmd_data_v_o, src_data_ready_and_o);
    end
    send(0, 64'hE7, 0, 1'b0);
    src_data_v_i[1] = 1'b0;
    drain("overflow");
    tests++;
    if (error_o !== 1'b1 || grant_o !== 1'b0) begin
      fails++;
      $display("FAIL overflow_sticky got e=%b g=%b exp 1/0", error_o, grant_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    int k = 0;
    exp_q.push_back('{1'b1, 0, 64'h66, 1'b1});
    for (int b = 0; b < 3; b++)
      exp_q.push_back('{1'b0, 0, 64'h6600, 1'b0});
    src_header_i[63:0] = 64'h66;
    src_has_data_i[0] = 1'b1;
    src_header_v_i[0] = 1'b1;
    src_data_i[63:0] = 64'h6600;
    src_last_i[0] = 1'b0;
    src_data_v_i[0] = 1'b1;
    do begin @(negedge clk); k++; end
    while (!src_header_ready_and_o[0] && k < 300);
    @(posedge clk); #1;
    src_header_v_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_header_v_o, cmd_data_v_o, src_header_ready_and_o,
         src_data_ready_and_o} !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset got hv=%b dv=%b hr=%b dr=%b exp 0",
               cmd_header_v_o, cmd_data_v_o, src_header_ready_and_o,
               src_data_ready_and_o);
    end
    drain("mid_reset");
    test_reset();
    test_contention(0);
  endtask

  initial begin
    rst_n = 1'b0;
    src_header_i = '0;
    src_header_v_i = '0;
    src_has_data_i = '0;
    src_data_i = '0;
    src_data_v_i = '0;
    src_last_i = '0;
    hdr_rdy = 1'b1;
    dat_rdy = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_header();
    test_contention(1);
    test_reset();
    test_burst_pair();
    test_backpressure();
    test_overflow();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
